// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keypad key codes, debounce states and row/col-to-code mapping
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} kp_state_e;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = KEY_0;
    case ({row, col})
      4'h0: code = KEY_1;
      4'h1: code = KEY_2;
      4'h2: code = KEY_3;
      4'h3: code = KEY_A;
      4'h4: code = KEY_4;
      4'h5: code = KEY_5;
      4'h6: code = KEY_6;
      4'h7: code = KEY_B;
      4'h8: code = KEY_7;
      4'h9: code = KEY_8;
      4'hA: code = KEY_9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = KEY_0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - keypad matrix lines and accepted-key outputs
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       pressed;
  logic       key_held;

  modport master (input row_in, output col_out, output key_code, output pressed, output key_held);
  modport slave  (output row_in, input col_out, input key_code, input pressed, input key_held);
endinterface

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - frame-level press/release debounce FSM
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_end_i,
  input  logic       frame_valid_i,
  input  logic [3:0] frame_code_i,
  output logic       pressed_o,
  output logic       key_held_o,
  output logic [3:0] key_code_o
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);

  kp_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    cand_q;
  logic [3:0]    key_code_q;
  logic          pressed_q;
  logic          key_held_q;

  logic [CW-1:0] cnt_inc;
  logic          cnt_hit;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign cnt_hit = (cnt_inc == CNT_MAX);

  // pressed_q defaults low every cycle, so an acceptance yields exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      key_code_q <= '0;
      pressed_q  <= 1'b0;
      key_held_q <= 1'b0;
    end else begin
      pressed_q <= 1'b0;
      if (frame_end_i) begin
        unique case (state_q)
          IDLE: begin
            if (frame_valid_i) begin
              cand_q <= frame_code_i;
              if (DEBOUNCE_CNT == 1) begin
                state_q    <= HELD;
                key_code_q <= frame_code_i;
                pressed_q  <= 1'b1;
                key_held_q <= 1'b1;
                cnt_q      <= '0;
              end else begin
                state_q <= DEBOUNCE;
                cnt_q   <= CW'(1);
              end
            end
          end
          DEBOUNCE: begin
            if (frame_valid_i && frame_code_i == cand_q) begin
              if (cnt_hit) begin
                state_q    <= HELD;
                key_code_q <= cand_q;
                pressed_q  <= 1'b1;
                key_held_q <= 1'b1;
                cnt_q      <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          HELD: begin
            if (!frame_valid_i) begin
              if (DEBOUNCE_CNT == 1) begin
                state_q    <= IDLE;
                key_held_q <= 1'b0;
                cnt_q      <= '0;
              end else begin
                state_q <= RELEASE;
                cnt_q   <= CW'(1);
              end
            end else begin
              cnt_q <= '0;
            end
          end
          default: begin
            if (!frame_valid_i) begin
              if (cnt_hit) begin
                state_q    <= IDLE;
                key_held_q <= 1'b0;
                cnt_q      <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= HELD;
              cnt_q   <= '0;
            end
          end
        endcase
      end
    end
  end

  assign pressed_o  = pressed_q;
  assign key_held_o = key_held_q;
  assign key_code_o = key_code_q;

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad column scanner with per-frame candidate capture
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 250,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_scan_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic          cand_valid_q, cand_valid_d;
  logic [3:0]    cand_code_q, cand_code_d;

  logic       dwell_last;
  logic       frame_end;
  logic [3:0] row_act;
  logic       row_hit;
  logic [1:0] hit_row;
  logic [3:0] sample_code;
  logic       frame_valid;
  logic [3:0] frame_code;

  assign dwell_last = (dwell_q == DW'(SCAN_DIV - 1));
  assign frame_end  = dwell_last && (col_q == 2'd3);
  assign row_act    = ~kp.row_in;
  assign row_hit    = |row_act;

  always_comb begin
    hit_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_act[r]) hit_row = 2'(r);
    end
  end

  assign sample_code = key_map(hit_row, col_q);

  // col3's own sample still counts when nothing was captured earlier in the frame
  assign frame_valid = cand_valid_q | (dwell_last & row_hit);
  assign frame_code  = cand_valid_q ? cand_code_q : sample_code;

  always_comb begin
    dwell_d      = dwell_q + DW'(1);
    col_d        = col_q;
    cand_valid_d = cand_valid_q;
    cand_code_d  = cand_code_q;
    if (dwell_last) begin
      dwell_d = '0;
      col_d   = col_q + 2'd1;
    end
    if (frame_end) begin
      cand_valid_d = 1'b0;
      cand_code_d  = '0;
    end else if (dwell_last && row_hit && !cand_valid_q) begin
      cand_valid_d = 1'b1;
      cand_code_d  = sample_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q      <= '0;
      col_q        <= '0;
      cand_valid_q <= 1'b0;
      cand_code_q  <= '0;
    end else begin
      dwell_q      <= dwell_d;
      col_q        <= col_d;
      cand_valid_q <= cand_valid_d;
      cand_code_q  <= cand_code_d;
    end
  end

  assign kp.col_out = ~(4'b0001 << col_q);

  keypad_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_end_i  (frame_end),
    .frame_valid_i(frame_valid),
    .frame_code_i (frame_code),
    .pressed_o    (kp.pressed),
    .key_held_o   (kp.key_held),
    .key_code_o   (kp.key_code)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys_now = '0;
  logic [3:0]  row_drv;

  always #5 clk = ~clk;

  keypad_scan_if kp();

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kp)
  );

  // Physical matrix: key bit r*4+c pulls row r low while column c is driven low
  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_now[r*4+c] && !kp.col_out[c]) row_drv[r] = 1'b0;
  end
  assign kp.row_in = row_drv;

  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [15:0] frame_keys [FR];

  bit m_held, m_strobe;
  int m_code, m_pend_code, m_pend_n, m_empty_n;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          exp_pulses;
    int          exp_code;
    bit          exp_held;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_strobe = 0; m_code = 0;
    m_pend_code = 0; m_pend_n = 0; m_empty_n = 0;
  endtask

  task automatic model_frame(input bit v, input int code);
    if (!m_held) begin
      if (v && m_pend_n > 0 && code == m_pend_code) m_pend_n++;
      else if (v && m_pend_n == 0) begin
        m_pend_code = code;
        m_pend_n = 1;
      end else m_pend_n = 0;
      if (m_pend_n == DB) begin
        m_held = 1; m_code = m_pend_code; m_strobe = 1;
        m_pend_n = 0; m_empty_n = 0;
      end
    end else begin
      if (v) m_empty_n = 0;
      else m_empty_n++;
      if (m_empty_n == DB) begin
        m_held = 0;
        m_empty_n = 0;
      end
    end
  endtask

  task automatic run_frame();
    bit res_v;
    int res_c;
    logic [3:0] ec;
    res_v = 0;
    res_c = 0;
    for (int i = 0; i < FR; i++) begin
      keys_now = frame_keys[i];
      ec = ~(4'b0001 << (i / SD));
      chk("col_out", kp.col_out, ec);
      chk("pressed", kp.pressed, (i == 0 && m_strobe) ? 1 : 0);
      chk("key_held", kp.key_held, m_held);
      chk("key_code", kp.key_code, m_code);
      if (i > 0 && kp.pressed) pulses++;
      if (i % SD == SD - 1) begin
        for (int r = 0; r < 4; r++) begin
          if (!res_v && frame_keys[i][r*4 + i/SD]) begin
            res_v = 1;
            res_c = keymap[r*4 + i/SD];
          end
        end
      end
      @(posedge clk); #1;
    end
    m_strobe = 0;
    model_frame(res_v, res_c);
    if (kp.pressed) pulses++;
  endtask

  task automatic run_phase(input logic [15:0] keys, input int frames);
    for (int i = 0; i < FR; i++) frame_keys[i] = keys;
    repeat (frames) run_frame();
  endtask

  task automatic check_phase(input string name, input int p0, input int ep, input int ecode, input bit eheld);
    chk({name, "_pulses"}, pulses - p0, ep);
    chk({name, "_code"}, kp.key_code, ecode);
    chk({name, "_held"}, kp.key_held, eheld);
  endtask

  initial begin
    int p0;
    logic [15:0] rk;

    vt[0]  = '{16'h0000, 2,  0, 0,  1'b0};
    vt[1]  = '{16'h0008, 10, 1, 10, 1'b1};
    vt[2]  = '{16'h0000, 2,  0, 10, 1'b1};
    vt[3]  = '{16'h0000, 1,  0, 10, 1'b0};
    vt[4]  = '{16'h1008, 4,  1, 14, 1'b1};
    vt[5]  = '{16'h0008, 4,  0, 14, 1'b1};
    vt[6]  = '{16'h0000, 3,  0, 14, 1'b0};
    vt[7]  = '{16'h0008, 4,  1, 10, 1'b1};
    vt[8]  = '{16'h0000, 1,  0, 10, 1'b1};
    vt[9]  = '{16'h0008, 2,  0, 10, 1'b1};
    vt[10] = '{16'h0000, 3,  0, 10, 1'b0};
    vt[11] = '{16'h0220, 4,  1, 5,  1'b1};
    vt[12] = '{16'h0000, 3,  0, 5,  1'b0};
    vt[13] = '{16'h8000, 4,  1, 13, 1'b1};
    vt[14] = '{16'h0000, 3,  0, 13, 1'b0};
    vt[15] = '{16'h0001, 4,  1, 1,  1'b1};
    vt[16] = '{16'h0000, 3,  0, 1,  1'b0};

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col_out", kp.col_out, 4'b1110);
    chk("rst_pressed", kp.pressed, 0);
    chk("rst_held", kp.key_held, 0);
    chk("rst_code", kp.key_code, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 17; v++) begin
      p0 = pulses;
      run_phase(vt[v].keys, vt[v].frames);
      check_phase($sformatf("vec%0d", v), p0, vt[v].exp_pulses, vt[v].exp_code, vt[v].exp_held);
    end

    // Bounce on key 5 that is released whenever column 1 is sampled
    p0 = pulses;
    for (int i = 0; i < FR; i++) frame_keys[i] = (i >= 8) ? 16'h0020 : 16'h0000;
    repeat (4) run_frame();
    check_phase("bounce_cyc", p0, 0, 1, 1'b0);
    p0 = pulses;
    for (int f = 0; f < 4; f++) run_phase((f % 2 == 0) ? 16'h0020 : 16'h0000, 1);
    check_phase("bounce_frm", p0, 0, 1, 1'b0);
    p0 = pulses;
    run_phase(16'h0020, 4);
    check_phase("bounce_stable", p0, 1, 5, 1'b1);
    run_phase(16'h0000, 3);

    // Asynchronous reset two frames into a debounce
    run_phase(16'h0020, 2);
    keys_now = 16'h0020;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("amid_col_out", kp.col_out, 4'b1110);
    chk("amid_pressed", kp.pressed, 0);
    chk("amid_held", kp.key_held, 0);
    chk("amid_code", kp.key_code, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    p0 = pulses;
    run_phase(16'h0020, 2);
    check_phase("post_rst_2f", p0, 0, 0, 1'b0);
    p0 = pulses;
    run_phase(16'h0020, 1);
    check_phase("post_rst_3f", p0, 1, 5, 1'b1);
    run_phase(16'h0000, 3);

    // Random key sets with occasional mid-frame glitches
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    rk = 16'h0000;
        2:       rk = 16'(1 << $urandom_range(0, 15));
        default: rk = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
      endcase
      for (int f = $urandom_range(1, 5); f > 0; f--) begin
        for (int i = 0; i < FR; i++) frame_keys[i] = rk;
        if ($urandom_range(0, 3) == 0)
          frame_keys[$urandom_range(0, FR - 1)] ^= 16'(1 << $urandom_range(0, 15));
        run_frame();
      end
    end
    run_phase(16'h0000, 4);
    chk("final_held", kp.key_held, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
